// File: rtl/spi_master_shifter_if.sv
// SPI master bus bundle: TX/RX FIFO handshakes plus the four SPI pins.
interface spi_master_shifter_if #(
  parameter int unsigned SPI_DATA_WIDTH = 8
);
  logic [SPI_DATA_WIDTH-1:0] tx_data;
  logic                      tx_empty;
  logic                      tx_load;
  logic                      rx_full;
  logic                      rx_store;
  logic [SPI_DATA_WIDTH-1:0] rx_data;
  logic                      sck;
  logic                      mosi;
  logic                      miso;
  logic                      ss_n;

  // Shifter side.
  modport master (
    input  tx_data, tx_empty, rx_full, miso,
    output tx_load, rx_store, rx_data, sck, mosi, ss_n
  );

  // FIFO / SPI slave side.
  modport slave (
    output tx_data, tx_empty, rx_full, miso,
    input  tx_load, rx_store, rx_data, sck, mosi, ss_n
  );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI master frame engine: pops a word from the TX FIFO, shifts it out on mosi while
// assembling miso into a word, then pushes that word to the RX FIFO.
module spi_master_shifter #(
  parameter int unsigned SPI_DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsb_first,
  input  logic [7:0]           clk_div,
  spi_master_shifter_if.master bus,
  output logic                 busy,
  output logic                 rx_overrun
);

  localparam int unsigned      EdgeW    = $clog2(2 * SPI_DATA_WIDTH);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * SPI_DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StDone, StGap} state_e;

  state_e                    state_q;
  logic [7:0]                div_q;
  logic [7:0]                div_lim_q;
  logic [EdgeW-1:0]          edge_q;
  logic [SPI_DATA_WIDTH-1:0] tx_sh_q;
  logic [SPI_DATA_WIDTH-1:0] rx_sh_q;
  logic                      cpol_q, cpha_q, lsb_q;
  logic                      sck_q, mosi_q, ss_n_q, busy_q;

  logic                      tick, start, leading, do_sample, do_shift, next_bit;
  logic [SPI_DATA_WIDTH-1:0] tx_shifted, rx_shifted;

  // Divider terminal count, edge classification and shift-register next values.
  always_comb begin
    tick       = (div_q == div_lim_q);
    start      = (state_q == StIdle) && enable && !bus.tx_empty;
    leading    = ~edge_q[0];
    do_sample  = leading ^ cpha_q;
    // With cpha=1 the first leading edge keeps bit 0 on the line.
    do_shift   = cpha_q ? (leading && (edge_q != '0)) : ~leading;
    next_bit   = lsb_q ? tx_sh_q[1] : tx_sh_q[SPI_DATA_WIDTH-2];
    tx_shifted = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    rx_shifted = lsb_q ? {bus.miso, rx_sh_q[SPI_DATA_WIDTH-1:1]}
                       : {rx_sh_q[SPI_DATA_WIDTH-2:0], bus.miso};
  end

  // FIFO strobes decode straight from the state register so they can never fire against a
  // full/empty flag; tx_load is also held off while reset is asserted.
  assign bus.tx_load  = start && !rst;
  assign bus.rx_store = (state_q == StDone) && !bus.rx_full;
  assign rx_overrun   = (state_q == StDone) && bus.rx_full;
  assign bus.rx_data  = rx_sh_q;
  assign bus.sck      = sck_q;
  assign bus.mosi     = mosi_q;
  assign bus.ss_n     = ss_n_q;
  assign busy         = busy_q;

  // Frame FSM with divider, edge counter and registered SPI pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      div_lim_q <= '0;
      edge_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      // New clk_div only takes effect at a terminal count, so sck never glitches.
      if (tick) begin
        div_q     <= '0;
        div_lim_q <= clk_div;
      end else begin
        div_q <= div_q + 8'd1;
      end

      unique case (state_q)
        StIdle: begin
          div_q     <= '0;
          div_lim_q <= clk_div;
          edge_q    <= '0;
          sck_q     <= cpol;
          mosi_q    <= 1'b0;
          ss_n_q    <= 1'b1;
          if (start) begin
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            lsb_q   <= lsb_first;
            tx_sh_q <= bus.tx_data;
            mosi_q  <= lsb_first ? bus.tx_data[0] : bus.tx_data[SPI_DATA_WIDTH-1];
            ss_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (tick) state_q <= StShift;
        end
        StShift: begin
          if (tick) begin
            sck_q  <= ~sck_q;
            edge_q <= edge_q + 1'b1;
            if (do_sample) rx_sh_q <= rx_shifted;
            if (do_shift) begin
              tx_sh_q <= tx_shifted;
              mosi_q  <= next_bit;
            end
            // The last toggle returns sck to cpol_q.
            if (edge_q == LastEdge) begin
              state_q <= StDone;
              ss_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
              edge_q  <= '0;
            end
          end
        end
        StDone: begin
          div_q     <= '0;
          div_lim_q <= clk_div;
          state_q   <= StGap;
        end
        StGap: begin
          if (tick) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/spi_master_shifter.md
SPI_MASTER_SHIFTER -- requirements
Module: spi_master_shifter

Interface
REQ-001 SHALL have parameter SPI_DATA_WIDTH, default 8, frame length in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port rst, input, 1 bit: reset is asynchronous and active-high.
REQ-004 SHALL have port enable, input, 1 bit: permits new frames to start.
REQ-005 SHALL have ports cpol and cpha, input, 1 bit each: SPI mode; sampled only in IDLE.
REQ-006 SHALL have port lsb_first, input, 1 bit: bit order; sampled only in IDLE.
REQ-007 SHALL have port clk_div, input, 8 bits: SCK half-period = clk_div+1 clk cycles.
REQ-008 SHALL have port tx_data, input, SPI_DATA_WIDTH: TX FIFO head word.
REQ-009 SHALL have port tx_empty, input, 1 bit: TX FIFO empty flag.
REQ-010 SHALL have port tx_load, output, 1 bit: one-cycle pop to TX FIFO.
REQ-011 SHALL have port rx_full, input, 1 bit: RX FIFO full flag.
REQ-012 SHALL have port rx_store, output, 1 bit: one-cycle push to RX FIFO.
REQ-013 SHALL have port rx_data, output, SPI_DATA_WIDTH: received word, valid while rx_store=1.
REQ-014 SHALL have ports sck, mosi, ss_n (outputs) and miso (input), 1 bit each.
REQ-015 SHALL have ports busy and rx_overrun, output, 1 bit each.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, SHIFT, DONE, GAP.
REQ-017 IDLE: when enable=1 and tx_empty=0, SHALL assert tx_load for exactly one cycle, capture tx_data into the shift register in that same cycle, latch cpol/cpha/lsb_first, and go to SETUP.
REQ-018 A divider counter SHALL count 0..clk_div and produce one tick at terminal count; it SHALL be cleared on every state entry.
REQ-019 SETUP: ss_n=0, mosi driven with first bit (MSB if lsb_first=0, else LSB); after one tick go to SHIFT.
REQ-020 SHIFT: each tick toggles sck; an edge counter SHALL count 2*SPI_DATA_WIDTH edges, then go to DONE.
REQ-021 cpha=0: leading edges SHALL sample miso; trailing edges SHALL shift mosi to the next bit.
REQ-022 cpha=1: leading edges SHALL shift mosi to the next bit (first leading edge presents bit 0); trailing edges SHALL sample miso.
REQ-023 sck SHALL equal cpol in all states except SHIFT.
REQ-024 DONE (one cycle): if rx_full=0, SHALL assert rx_store with rx_data = assembled word in the configured bit order; if rx_full=1, SHALL not assert rx_store and SHALL pulse rx_overrun for one cycle, discarding the word.
REQ-025 GAP: ss_n=1 for one tick, then return to IDLE; back-to-back frames are thereby separated by one half-period.
REQ-026 Deasserting enable mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-027 tx_load SHALL never assert while tx_empty=1; rx_store SHALL never assert while rx_full=1.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 clk_div changes mid-frame SHALL take effect at the next divider terminal count; no glitch shorter than one clk on sck.
REQ-030 mosi SHALL be 0 in IDLE and GAP.

Reset
REQ-031 On rst=1, immediately and asynchronously: state=IDLE, sck=0, ss_n=1, mosi=0, tx_load=0, rx_store=0, rx_overrun=0, busy=0, rx_data=0, all counters 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no rx_store and no further tx_load; the first frame after release SHALL use the sck idle level per cpol once in IDLE (one cycle after release).

Verification
REQ-033 Mode 0, clk_div=0, lsb_first=0, tx_data=0xA5, miso looped to mosi -> one tx_load; mosi bits 1,0,1,0,0,1,0,1; 8 sck rising edges; rx_store with rx_data=0xA5; ss_n low for 17 cycles.
REQ-034 Mode 3, clk_div=3, lsb_first=1, tx_data=0x01, miso tied 1 -> sck idle 1, half-period 4 cycles, first bit on mosi=1 then 0s, rx_data=0xFF.
REQ-035 Three words queued (tx_empty low for three pops), enable held -> exactly three tx_load pulses, three rx_store pulses, ss_n high for one half-period between frames.
REQ-036 rx_full=1 during DONE -> rx_store=0, rx_overrun=1 for one cycle, FSM proceeds to GAP/IDLE normally.
REQ-037 rst asserted at edge 5 of a frame -> same-cycle outputs at reset values; no rx_store; next frame after release completes correctly.
REQ-038 enable dropped during SHIFT with tx_empty=0 -> current frame completes, no further tx_load, busy=0 after GAP.
